// File: rtl/cpu_ctrl_pkg.sv
// Shared control-sequencer definitions: opcodes, step states and the datapath strobe bundle.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OPC_LD  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OPC_LDI = 5'b00001;
    localparam logic [OPCODE_W-1:0] OPC_ST  = 5'b00010;

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        INS_LD, INS_LDI, INS_ST
    } instr_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic read;
        logic write;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic grb;
        logic ba_out;
        logic y_in;
        logic c_out;
        logic gra;
        logic r_in;
        logic r_out;
        logic alu_add;
    } strobe_t;

    // T index of a state; IDLE and FAULT report 0.
    function automatic logic [3:0] step_of(input state_e s);
        if (s == ST_IDLE || s == ST_FAULT)
            return 4'd0;
        return 4'(s) - 4'd1;
    endfunction

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Handshake and datapath-strobe bundle between the sequencer and its environment.
interface mem_op_sequencer_if #(
    parameter int OPC_W  = 5,
    parameter int STEP_W = 4
);
    logic              start;
    logic [OPC_W-1:0]  ir_opcode;
    logic              mem_ready;
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin;
    logic MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout;
    logic              alu_add;
    logic              busy;
    logic              done;
    logic              error;
    logic [STEP_W-1:0] step;

    modport master (
        input  start, ir_opcode, mem_ready,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin,
               MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout,
               alu_add, busy, done, error, step
    );

    modport slave (
        output start, ir_opcode, mem_ready,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin,
               MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout,
               alu_add, busy, done, error, step
    );
endinterface

// File: rtl/mem_op_sequencer_mem_wait_timer.sv
// Loadable down-counter bounding how long a memory step may wait for mem_ready.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic en,
    output logic expired
);
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = 8'(TIMEOUT);
        else if (en && count_q != 8'd0)
            count_d = count_q - 8'd1;
    end

    always_ff @(posedge clock) begin
        if (clear)
            count_q <= 8'd0;
        else
            count_q <= count_d;
    end

    // Last permitted waiting cycle: no mem_ready now means timeout at the next edge.
    assign expired = (count_q == 8'd1);

endmodule

// File: rtl/mem_op_sequencer.sv
// Control-step sequencer for ld/ldi/st: fetch, decode, address calc and memory steps with timeout.
module mem_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W       = 5,
    parameter int STEP_W      = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                clear,
    mem_op_sequencer_if.master  bus
);
    state_e           state_q, state_d;
    instr_e           ins_q, ins_d;
    strobe_t          strb;
    logic             done_c, error_c;
    logic             mem_step, expired;
    logic [OPC_W-1:0] opc;

    assign opc = bus.ir_opcode;
    assign mem_step = (state_q == ST_T1)
                   || (state_q == ST_T6 && ins_q == INS_LD)
                   || (state_q == ST_T7 && ins_q == INS_ST);

    mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .clear   (clear),
        .load    (!mem_step),
        .en      (mem_step && !bus.mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        strb    = '0;
        done_c  = 1'b0;
        error_c = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_T0;
            ST_T0: begin
                strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; strb.z_in = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                strb.zlow_out = 1'b1; strb.pc_in = 1'b1; strb.read = 1'b1; strb.mdr_in = 1'b1;
                state_d = ST_T2;
            end
            ST_T2: begin
                strb.mdr_out = 1'b1; strb.ir_in = 1'b1;
                state_d = ST_T3;
                if (opc == OPC_W'(OPC_LD))       ins_d = INS_LD;
                else if (opc == OPC_W'(OPC_LDI)) ins_d = INS_LDI;
                else if (opc == OPC_W'(OPC_ST))  ins_d = INS_ST;
                else                             state_d = ST_FAULT;
            end
            ST_T3: begin
                strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1;
                state_d = ST_T4;
            end
            ST_T4: begin
                strb.c_out = 1'b1; strb.alu_add = 1'b1; strb.z_in = 1'b1;
                state_d = ST_T5;
            end
            ST_T5: begin
                strb.zlow_out = 1'b1;
                if (ins_q == INS_LDI) begin
                    strb.gra = 1'b1; strb.r_in = 1'b1;
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    strb.mar_in = 1'b1;
                    state_d = ST_T6;
                end
            end
            ST_T6: begin
                strb.mdr_in = 1'b1;
                if (ins_q == INS_LD) strb.read = 1'b1;
                else begin strb.gra = 1'b1; strb.r_out = 1'b1; end
                state_d = ST_T7;
            end
            ST_T7: begin
                strb.mdr_out = 1'b1;
                if (ins_q == INS_LD) begin strb.gra = 1'b1; strb.r_in = 1'b1; end
                else strb.write = 1'b1;
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                error_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A memory step without mem_ready holds its strobes; mem_ready on the last allowed cycle still wins.
        if (mem_step && !bus.mem_ready) begin
            done_c  = 1'b0;
            state_d = expired ? ST_FAULT : state_q;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            ins_q   <= INS_LD;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
        end
    end

    assign bus.PCout   = strb.pc_out;
    assign bus.MARin   = strb.mar_in;
    assign bus.IncPC   = strb.inc_pc;
    assign bus.Zin     = strb.z_in;
    assign bus.Zlowout = strb.zlow_out;
    assign bus.PCin    = strb.pc_in;
    assign bus.Read    = strb.read;
    assign bus.Write   = strb.write;
    assign bus.MDRin   = strb.mdr_in;
    assign bus.MDRout  = strb.mdr_out;
    assign bus.IRin    = strb.ir_in;
    assign bus.Grb     = strb.grb;
    assign bus.BAout   = strb.ba_out;
    assign bus.Yin     = strb.y_in;
    assign bus.Cout    = strb.c_out;
    assign bus.Gra     = strb.gra;
    assign bus.Rin     = strb.r_in;
    assign bus.Rout    = strb.r_out;
    assign bus.alu_add = strb.alu_add;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_c;
    assign bus.error   = error_c;
    assign bus.step    = STEP_W'(step_of(state_q));

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Directed scoreboard bench: each instruction pushes its expected per-cycle trace, every cycle pops one entry.
module tb_mem_op_sequencer;

    localparam logic [4:0] L_LD  = 5'b00000;
    localparam logic [4:0] L_LDI = 5'b00001;
    localparam logic [4:0] L_ST  = 5'b00010;
    localparam logic [4:0] L_BAD = 5'b00101;
    localparam int I_LD = 0, I_LDI = 1, I_ST = 2;

    // Strobe vector bit positions, PCout first down to alu_add.
    localparam logic [18:0] M_PCOUT = 19'd1 << 18, M_MARIN = 19'd1 << 17, M_INCPC = 19'd1 << 16;
    localparam logic [18:0] M_ZIN   = 19'd1 << 15, M_ZLOW  = 19'd1 << 14, M_PCIN  = 19'd1 << 13;
    localparam logic [18:0] M_READ  = 19'd1 << 12, M_WRITE = 19'd1 << 11, M_MDRIN = 19'd1 << 10;
    localparam logic [18:0] M_MDROUT = 19'd1 << 9, M_IRIN  = 19'd1 << 8,  M_GRB   = 19'd1 << 7;
    localparam logic [18:0] M_BAOUT = 19'd1 << 6,  M_YIN   = 19'd1 << 5,  M_COUT  = 19'd1 << 4;
    localparam logic [18:0] M_GRA   = 19'd1 << 3,  M_RIN   = 19'd1 << 2,  M_ROUT  = 19'd1 << 1;
    localparam logic [18:0] M_ALU   = 19'd1;

    typedef struct {
        string       tag;
        logic [18:0] strb;
        logic [3:0]  step;
        logic        busy;
        logic        done;
        logic        error;
    } exp_t;

    logic clock = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mem_op_sequencer_if #(.OPC_W(5), .STEP_W(4)) bus ();

    mem_op_sequencer #(.OPC_W(5), .STEP_W(4), .MEM_TIMEOUT(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [18:0] exp_strb(input int ins, input int t);
        logic [18:0] v;
        v = '0;
        case (t)
            0: v = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
            1: v = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
            2: v = M_MDROUT | M_IRIN;
            3: v = M_GRB | M_BAOUT | M_YIN;
            4: v = M_COUT | M_ALU | M_ZIN;
            5: v = (ins == I_LDI) ? (M_ZLOW | M_GRA | M_RIN) : (M_ZLOW | M_MARIN);
            6: v = (ins == I_LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
            7: v = (ins == I_LD) ? (M_MDROUT | M_GRA | M_RIN) : (M_MDROUT | M_WRITE);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input logic [18:0] s, input logic [3:0] stp,
                        input logic b, input logic d, input logic er);
        exp_t e;
        e.tag = tag; e.strb = s; e.step = stp; e.busy = b; e.done = d; e.error = er;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        push(tag, 19'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_t(input string tag, input int ins, input int t, input logic d);
        push($sformatf("%s_T%0d", tag, t), exp_strb(ins, t), 4'(t), 1'b1, d, 1'b0);
    endtask

    task automatic push_fault(input string tag);
        push({tag, "_fault"}, 19'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    endtask

    // One clock cycle: drive inputs just after the edge, compare outputs at the falling edge.
    task automatic tick(input logic st, input logic rdy, input logic [4:0] opc, input logic clr);
        exp_t        e;
        logic [18:0] obs;
        @(posedge clock);
        #1;
        bus.start     = st;
        bus.mem_ready = rdy;
        bus.ir_opcode = opc;
        clear         = clr;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: DUT cycle with no expected entry, got none required one");
        end else begin
            e = exp_q.pop_front();
            obs = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin, bus.Read,
                   bus.Write, bus.MDRin, bus.MDRout, bus.IRin, bus.Grb, bus.BAout, bus.Yin,
                   bus.Cout, bus.Gra, bus.Rin, bus.Rout, bus.alu_add};
            checks += 5;
            assert (obs === e.strb) else begin
                errors++;
                $error("FAIL %s strobes got=%b exp=%b", e.tag, obs, e.strb);
            end
            assert (bus.step === e.step) else begin
                errors++;
                $error("FAIL %s step got=%0d exp=%0d", e.tag, bus.step, e.step);
            end
            assert (bus.busy === e.busy) else begin
                errors++;
                $error("FAIL %s busy got=%b exp=%b", e.tag, bus.busy, e.busy);
            end
            assert (bus.done === e.done) else begin
                errors++;
                $error("FAIL %s done got=%b exp=%b", e.tag, bus.done, e.done);
            end
            assert (bus.error === e.error) else begin
                errors++;
                $error("FAIL %s error got=%b exp=%b", e.tag, bus.error, e.error);
            end
        end
    endtask

    initial begin
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir_opcode = 5'b0;

        // Reset state
        for (int i = 0; i < 3; i++) push_idle("reset");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, L_LD, 1'b1);
        $display("txn reset: errors so far=%0d", errors);

        // ld with zero-wait memory; start during T7 must be ignored
        push_idle("ld_start");
        for (int t = 0; t < 8; t++) push_t("ld", I_LD, t, t == 7);
        push_idle("ld_end");
        tick(1'b1, 1'b1, L_LD, 1'b0);
        for (int t = 0; t < 8; t++) tick(t == 7, 1'b1, L_LD, 1'b0);
        tick(1'b0, 1'b1, L_LD, 1'b0);
        $display("txn ld zero-wait: errors so far=%0d", errors);

        // ldi finishes at T5 with no T6
        push_idle("ldi_start");
        for (int t = 0; t < 6; t++) push_t("ldi", I_LDI, t, t == 5);
        push_idle("ldi_end");
        tick(1'b1, 1'b1, L_LDI, 1'b0);
        for (int t = 0; t < 6; t++) tick(1'b0, 1'b1, L_LDI, 1'b0);
        tick(1'b0, 1'b1, L_LDI, 1'b0);
        $display("txn ldi: errors so far=%0d", errors);

        // st with three wait cycles in T7
        push_idle("st_start");
        for (int t = 0; t < 7; t++) push_t("st", I_ST, t, 1'b0);
        for (int k = 0; k < 3; k++) push_t("st_wait", I_ST, 7, 1'b0);
        push_t("st", I_ST, 7, 1'b1);
        push_idle("st_end");
        tick(1'b1, 1'b1, L_ST, 1'b0);
        for (int t = 0; t < 7; t++) tick(1'b0, 1'b1, L_ST, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, L_ST, 1'b0);
        tick(1'b0, 1'b1, L_ST, 1'b0);
        tick(1'b0, 1'b0, L_ST, 1'b0);
        $display("txn st wait=3: errors so far=%0d", errors);

        // ld timeout in T6 after 4 waiting cycles
        push_idle("ldto_start");
        for (int t = 0; t < 6; t++) push_t("ldto", I_LD, t, 1'b0);
        for (int k = 0; k < 4; k++) push_t("ldto_wait", I_LD, 6, 1'b0);
        push_fault("ldto");
        push_idle("ldto_end");
        tick(1'b1, 1'b1, L_LD, 1'b0);
        for (int t = 0; t < 6; t++) tick(1'b0, 1'b1, L_LD, 1'b0);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, L_LD, 1'b0);
        tick(1'b0, 1'b0, L_LD, 1'b0);
        $display("txn ld timeout: errors so far=%0d", errors);

        // ld where mem_ready arrives on the last allowed T1 cycle
        push_idle("ldedge_start");
        push_t("ldedge", I_LD, 0, 1'b0);
        for (int k = 0; k < 4; k++) push_t("ldedge_wait", I_LD, 1, 1'b0);
        for (int t = 2; t < 8; t++) push_t("ldedge", I_LD, t, t == 7);
        push_idle("ldedge_end");
        tick(1'b1, 1'b1, L_LD, 1'b0);
        tick(1'b0, 1'b1, L_LD, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, L_LD, 1'b0);
        tick(1'b0, 1'b1, L_LD, 1'b0);
        for (int t = 2; t < 8; t++) tick(1'b0, 1'b1, L_LD, 1'b0);
        tick(1'b0, 1'b1, L_LD, 1'b0);
        $display("txn ld ready-at-timeout: errors so far=%0d", errors);

        // Illegal opcode faults after T2
        push_idle("bad_start");
        for (int t = 0; t < 3; t++) push_t("bad", I_LD, t, 1'b0);
        push_fault("bad");
        push_idle("bad_end");
        tick(1'b1, 1'b1, L_BAD, 1'b0);
        for (int t = 0; t < 3; t++) tick(1'b0, 1'b1, L_BAD, 1'b0);
        tick(1'b0, 1'b1, L_BAD, 1'b0);
        tick(1'b0, 1'b1, L_BAD, 1'b0);
        $display("txn illegal opcode: errors so far=%0d", errors);

        // clear during a T1 wait, then a fresh ldi
        push_idle("clr_start");
        push_t("clr", I_LD, 0, 1'b0);
        push_t("clr_wait", I_LD, 1, 1'b0);
        push_t("clr_wait", I_LD, 1, 1'b0);
        push_idle("clr_after");
        for (int t = 0; t < 6; t++) push_t("clr_ldi", I_LDI, t, t == 5);
        push_idle("clr_end");
        tick(1'b1, 1'b1, L_LD, 1'b0);
        tick(1'b0, 1'b0, L_LD, 1'b0);
        tick(1'b0, 1'b0, L_LD, 1'b0);
        tick(1'b0, 1'b0, L_LD, 1'b1);
        tick(1'b1, 1'b1, L_LDI, 1'b0);
        for (int t = 0; t < 6; t++) tick(1'b0, 1'b1, L_LDI, 1'b0);
        tick(1'b0, 1'b1, L_LDI, 1'b0);
        $display("txn clear mid-wait: errors so far=%0d", errors);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain leftover=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_op_sequencer.md
# mem_op_sequencer

Control-step sequencer for the datapath's memory-class instructions (ld, ldi, st). It replaces hand-driven T0..T7 control strobes with a synchronous state machine that fetches the instruction, decodes the opcode from IR, and walks the per-instruction control steps. Memory steps stall on a `mem_ready` handshake and are bounded by a timeout. It sits between the instruction register and the DataPath control inputs.

## Interface
- `OPC_W`, 5: opcode field width (IR[31:27]).
- `STEP_W`, 4: width of the `step` debug output.
- `MEM_TIMEOUT`, 16: max cycles a memory step waits for `mem_ready`, range 1..255.

- `clock`  in  1  system clock, all state updates on rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one instruction; sampled only in IDLE.
- `ir_opcode`  in  OPC_W  opcode from IR; sampled at the end of T2.
- `mem_ready`  in  1  memory completed the current Read/Write.
- `PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout`  out  1 each  datapath strobes.
- `alu_add`  out  1  selects ADD in the ALU.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  one-cycle pulse on illegal opcode or memory timeout.
- `step`  out  STEP_W  current T index (0..7); 0 in IDLE.

## Operation
- States: IDLE, T0..T7, plus a FAULT state held for one cycle.
- Strobes are Moore decodes of the current state. They are all 0 in IDLE and FAULT.
- Fetch, common to all opcodes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. This is a memory step.
  - T2: MDRout, IRin.
- Decode at the end of T2:
  - ld = 5'b00000, ldi = 5'b00001, st = 5'b00010.
  - Any other opcode: T2 → FAULT.
- Address calculation, common to all three:
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_add, Zin.
- ld:
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Memory step.
  - T7: MDRout, Gra, Rin. Then done.
- ldi:
  - T5: Zlowout, Gra, Rin. Then done; no T6/T7.
- st:
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin (MDR loads from bus).
  - T7: MDRout, Write. Memory step. Then done.
- Memory step rule:
  - Strobes are held while waiting.
  - Advance on the first rising edge with `mem_ready`=1.
  - The wait counter resets on entry to each memory step.
  - If `MEM_TIMEOUT` cycles elapse with no `mem_ready`: go to FAULT.
- FAULT: pulses `error`, then returns to IDLE.
- Last step: pulses `done` in the final step's cycle, then IDLE. A `start` seen in that final cycle is ignored.
- `start` outside IDLE is ignored; there is no queueing.
- `mem_ready` outside a memory step is ignored.

## Timing
- Reset: `clear`=1 at a rising edge forces IDLE, zeroes the wait counter and drives every output to 0. This holds from any state, including mid-memory-wait.
- Sequence starts on the edge where IDLE samples `start`=1: T0 in the next cycle.
- Latency with zero-wait memory (`mem_ready` held high), counted from that edge to return to IDLE:
  - ld: 8 cycles.
  - ldi: 6 cycles.
  - st: 8 cycles.
- Each memory step adds k cycles when `mem_ready` first rises after k wait cycles.
- Timeout: FAULT is entered on the edge after the `MEM_TIMEOUT`-th waiting cycle. `mem_ready` arriving in that same cycle wins, and the step completes.
- `done` and `error` are never high together.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the opcode constants (ld, ldi, st);
  - the state enum (IDLE, T0..T7, FAULT);
  - the strobe bundle typedef, shared with future ALU/branch sequencers.
- One sub-module, `mem_wait_timer`: a loadable down-counter with inputs `clock`, `clear`, `load`, `en` and output `expired`.

## Test plan
- ld, `mem_ready` held 1, `ir_opcode`=00000 → `step` runs 0..7 over 8 cycles; `done` pulses at T7; T7 asserts MDRout, Gra, Rin.
- ldi, opcode 00001 → `done` pulses at T5; Gra and Rin high in T5; no Read in T6.
- st, `mem_ready` low for 3 cycles in T7 → Write held for 4 cycles; `done` pulses on the 4th.
- ld, `MEM_TIMEOUT`=4, `mem_ready` never high in T6 → `error` pulses after 4 wait cycles; `done` never asserts; returns to IDLE.
- Illegal opcode 00101 → FAULT after T2; `error` pulse; no T3 strobes.
- `clear` asserted during a T1 wait → all outputs 0 next cycle, `busy`=0; a new `start` then runs a clean T0.
